sevenseg_scan_decoder: RTL and testbench



---
 rtl/sevenseg_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// Receive-side monitor for an 8-digit multiplexed seven-segment bus.
// Debounces each digit dwell, decodes it back to BCD and assembles 8-digit frames.
module sevenseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  AN,
  input  logic [6:0]  seg,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic [7:0]  err,
  output logic        capture_strobe,
  output logic [2:0]  capture_idx,
  output logic        frame_valid,
  output logic        illegal_an,
  output logic        stalled
);
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] S_SAT  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] S_FIRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);

  localparam logic SETTLE = 1'b0;
  localparam logic HELD   = 1'b1;

  logic [7:0]    an_m, an_s;
  logic [6:0]    seg_m, seg_s;
  logic [14:0]   prev;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          state;
  logic [7:0]    seen;

  logic          changed, an_changed, fire, stall_hit;
  logic          one_low, all_high;
  logic [7:0]    an_low, seen_nxt;
  logic [2:0]    idx;
  logic [3:0]    dval;
  logic          dblank, derr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_m  <= '1;
      an_s  <= '1;
      seg_m <= '1;
      seg_s <= '1;
      prev  <= '1;
    end else begin
      an_m  <= AN;
      an_s  <= an_m;
      seg_m <= seg;
      seg_s <= seg_m;
      prev  <= {an_s, seg_s};
    end
  end

  // The change-detect edge already counts as the first stable sample, so the
  // dwell is accepted when the counter shows STABLE_CYCLES-2 further repeats.
  always_comb begin
    changed    = ({an_s, seg_s} != prev);
    an_changed = (an_s != prev[14:7]);
    an_low     = ~an_s;
    one_low    = (an_low != '0) && ((an_low & (an_low - 8'd1)) == '0);
    all_high   = (an_low == '0);
    fire       = (state == SETTLE) && !changed && (scnt == S_FIRE);
    stall_hit  = !an_changed && (tcnt == T_SAT - TW'(1));
    idx        = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
    seen_nxt   = seen | (8'd1 << idx);
  end

  always_comb begin
    dval   = 4'hF;
    dblank = 1'b0;
    derr   = 1'b0;
    case (seg_s)
      7'h40: dval = 4'd0;
      7'h79: dval = 4'd1;
      7'h24: dval = 4'd2;
      7'h30: dval = 4'd3;
      7'h19: dval = 4'd4;
      7'h12: dval = 4'd5;
      7'h02: dval = 4'd6;
      7'h78: dval = 4'd7;
      7'h00: dval = 4'd8;
      7'h10: dval = 4'd9;
      7'h7F: begin
        dval   = 4'd0;
        dblank = 1'b1;
      end
      default: derr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SETTLE;
      scnt  <= '0;
      tcnt  <= '0;
    end else begin
      if (changed) begin
        scnt  <= '0;
        state <= SETTLE;
      end else begin
        if (scnt != S_SAT) scnt <= scnt + SW'(1);
        if (fire) state <= HELD;
      end
      if (an_changed) tcnt <= '0;
      else if (tcnt != T_SAT) tcnt <= tcnt + TW'(1);
    end
  end

  assign stalled = (tcnt == T_SAT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits         <= '0;
      blank          <= '1;
      err            <= '0;
      capture_strobe <= 1'b0;
      capture_idx    <= '0;
      frame_valid    <= 1'b0;
      illegal_an     <= 1'b0;
      seen           <= '0;
    end else begin
      capture_strobe <= fire && one_low;
      illegal_an     <= fire && !one_low && !all_high;
      frame_valid    <= 1'b0;
      if (fire && one_low) begin
        capture_idx                <= idx;
        digits[{idx, 2'b00} +: 4]  <= dval;
        blank[idx]                 <= dblank;
        err[idx]                   <= derr;
        if (seen_nxt == '1) begin
          seen        <= '0;
          frame_valid <= 1'b1;
        end else begin
          seen <= seen_nxt;
        end
      end else if (stall_hit) begin
        seen <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboarded bench: stimulus is a list of bus segments; a behavioural model
// predicts each accepted dwell and a monitor compares DUT events against it.
module tb_sevenseg_scan_decoder;
  localparam int unsigned S = 4;
  localparam int unsigned T = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  AN;
  logic [6:0]  seg;
  logic [31:0] digits;
  logic [7:0]  blank, err;
  logic        capture_strobe, frame_valid, illegal_an, stalled;
  logic [2:0]  capture_idx;

  sevenseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .AN(AN), .seg(seg),
    .digits(digits), .blank(blank), .err(err),
    .capture_strobe(capture_strobe), .capture_idx(capture_idx),
    .frame_valid(frame_valid), .illegal_an(illegal_an), .stalled(stalled)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ill;
    int          t;
    logic [2:0]  idx;
    logic [31:0] dg;
    logic [7:0]  bl;
    logic [7:0]  er;
    bit          fv;
  } ev_t;
  ev_t q[$];
  ev_t mon_e;

  logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [31:0] m_dig;
  logic [7:0]  m_bl, m_er, m_seen, m_an_prev;
  logic [6:0]  m_seg_prev;
  int          m_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_dig = '0; m_bl = '1; m_er = '0; m_seen = '0;
    m_an_prev = '1; m_seg_prev = '1; m_run = 0;
    q.delete();
  endtask

  // Present a segment held for len cycles and predict what it produces.
  task automatic issue(input logic [7:0] an, input logic [6:0] sg, input int len);
    ev_t e;
    int  zeros, pos, val;
    bit  newv;
    newv = (an != m_an_prev) || (sg != m_seg_prev);
    if (an == m_an_prev) m_run += len;
    else m_run = len;
    if (newv && len >= int'(S)) begin
      zeros = 8 - $countones(an);
      e = '{default: 0};
      e.t = cyc + 2 + int'(S);
      if (zeros == 1) begin
        pos = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) pos = i;
        val = -1;
        for (int k = 0; k < 10; k++) if (pat[k] == sg) val = k;
        if (sg == 7'h7F) begin
          m_dig[4*pos +: 4] = 4'h0; m_bl[pos] = 1'b1; m_er[pos] = 1'b0;
        end else if (val < 0) begin
          m_dig[4*pos +: 4] = 4'hF; m_bl[pos] = 1'b0; m_er[pos] = 1'b1;
        end else begin
          m_dig[4*pos +: 4] = 4'(val); m_bl[pos] = 1'b0; m_er[pos] = 1'b0;
        end
        m_seen[pos] = 1'b1;
        e.fv = (m_seen == 8'hFF);
        if (e.fv) m_seen = '0;
        e.idx = 3'(pos);
        e.dg = m_dig; e.bl = m_bl; e.er = m_er;
        q.push_back(e);
      end else if (zeros >= 2) begin
        e.ill = 1'b1;
        q.push_back(e);
      end
    end
    if (m_run > int'(T)) m_seen = '0;
    m_an_prev = an; m_seg_prev = sg;
    AN = an; seg = sg;
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] sg, input int len);
    issue(an, sg, len);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic digit(input int d, input logic [6:0] sg);
    drive(~(8'd1 << d), sg, 10);
    drive(8'hFF, 7'h7F, 3);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_digits"}, digits, 32'h0);
    chk({tag, "_blank"}, blank, 8'hFF);
    chk({tag, "_err"}, err, 8'h00);
    chk({tag, "_strobe"}, capture_strobe, 1'b0);
    chk({tag, "_idx"}, capture_idx, 3'd0);
    chk({tag, "_frame"}, frame_valid, 1'b0);
    chk({tag, "_illegal"}, illegal_an, 1'b0);
    chk({tag, "_stalled"}, stalled, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      while (q.size() != 0 && q[0].t < cyc) begin
        mon_e = q.pop_front();
        chk("missed_event_time", 32'(cyc), 32'(mon_e.t));
      end
      if (capture_strobe || illegal_an) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {30'd0, capture_strobe, illegal_an}, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("event_time", 32'(cyc), 32'(mon_e.t));
          chk("illegal_an", illegal_an, mon_e.ill);
          chk("capture_strobe", capture_strobe, !mon_e.ill);
          chk("frame_valid", frame_valid, mon_e.fv);
          if (!mon_e.ill) begin
            chk("capture_idx", capture_idx, mon_e.idx);
            chk("digits", digits, mon_e.dg);
            chk("blank", blank, mon_e.bl);
            chk("err", err, mon_e.er);
          end
        end
      end else if (frame_valid) begin
        chk("frame_without_strobe", frame_valid, 1'b0);
      end
    end
  end

  initial begin
    logic [7:0] an;
    logic [6:0] sg;
    int n, r, a, b;
    reset_n = 1'b1; AN = 8'hFF; seg = 7'h7F;
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(8'hFF, 7'h7F, 5);

    // single long dwell: exactly one capture
    drive(8'hFE, 7'h24, 40);
    drive(8'hFF, 7'h7F, 4);

    // full scan 1..8
    for (int d = 0; d < 8; d++) digit(d, pat[d + 1]);
    chk("scan_digits", digits, 32'h87654321);

    // glitch on digit 3
    drive(8'hF7, 7'h19, 2);
    drive(8'hF7, 7'h18, 1);
    drive(8'hF7, 7'h19, 10);
    drive(8'hFF, 7'h7F, 3);

    // blank and illegal segment patterns, then complete the frame
    digit(5, 7'h7F);
    digit(6, 7'h7E);
    chk("blank5", blank[5], 1'b1);
    chk("err6", err[6], 1'b1);
    chk("nibble6", digits[27:24], 4'hF);
    for (int d = 0; d < 8; d++) if (d != 5 && d != 6) digit(d, pat[d]);

    // multiple anodes low, then a long blanking interval
    drive(8'hFC, 7'h40, 12);
    drive(8'hFF, 7'h7F, 20);
    chk("digits_after_illegal", digits, m_dig);

    // randomized segments, AN always changes so no stall occurs
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8) an = ~(8'd1 << r);
      else if (r == 8) an = 8'hFF;
      else begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        an = 8'($urandom) & ~(8'd1 << a) & ~(8'd1 << b);
      end
      if (an == m_an_prev) an = (an == 8'hFF) ? 8'hFE : 8'hFF;
      r = $urandom_range(0, 9);
      if (r < 7) sg = pat[$urandom_range(0, 9)];
      else if (r == 7) sg = 7'h7F;
      else sg = 7'($urandom);
      drive(an, sg, $urandom_range(1, 14));
    end
    drive(8'hFF, 7'h7F, 4);

    // stall: freeze on the 5th digit
    for (int d = 0; d < 4; d++) digit(d, pat[d]);
    n = cyc;
    issue(8'hEF, pat[4], 100);
    wait_neg(n + 2 + int'(T));
    chk("stalled_before", stalled, 1'b0);
    @(negedge clk);
    chk("stalled_at_timeout", stalled, 1'b1);
    while (cyc < n + 100) begin @(posedge clk); #1; end
    n = cyc;
    issue(8'hFF, 7'h7F, 6);
    wait_neg(n + 2);
    chk("stalled_held", stalled, 1'b1);
    @(negedge clk);
    chk("stalled_cleared", stalled, 1'b0);
    while (cyc < n + 6) begin @(posedge clk); #1; end
    for (int d = 7; d >= 0; d--) digit(d, pat[9 - d]);

    // asynchronous reset in the middle of a dwell and of a frame
    digit(2, pat[3]);
    issue(8'hFD, pat[7], 20);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    AN = 8'hFF; seg = 7'h7F;
    model_reset();
    #1 check_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(8'hFF, 7'h7F, 6);
    for (int d = 0; d < 8; d++) digit(d, pat[(d + 3) % 10]);
    drive(8'hFF, 7'h7F, 10);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
